// File: rtl/factor_game_ctrl.sv
// Game sequencer for the factorization game: mode FSM, lives counter and BCD countdown timer.
// Optional build macro TIME_BONUS_EN adds BONUS_SEC seconds to the timer on each correct factor.
module factor_game_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int TIME_LIMIT = 60,
  parameter int HP_INIT    = 3,
  parameter int BONUS_SEC  = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] KEY,
  input  logic [1:0] JUDG,
  input  logic       WRONG,
  output logic [2:0] MODE,
  output logic       JUDGE_REQ,
  output logic       INPUT_CLR,
  output logic [1:0] HP_OUT,
  output logic [3:0] COUNT1_OUT,
  output logic [3:0] COUNT2_OUT,
  output logic [3:0] COUNT3_OUT,
  output logic       LEDR
);

  // state   | meaning
  // S_IDLE  | waiting for start key
  // S_READY | waiting for enter-input key
  // S_INPUT | timer running, waiting for submit
  // S_JUDGE | timer frozen, waiting for judge result
  // S_CLEAR | puzzle solved, LEDR lit
  // S_OVER  | out of time or lives
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_INPUT = 3'd2,
    S_JUDGE = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [11:0]    TL_BCD    = {4'(TIME_LIMIT / 100), 4'((TIME_LIMIT / 10) % 10),
                                          4'(TIME_LIMIT % 10)};
  localparam logic [1:0]     HP_RST    = 2'(HP_INIT);

  state_t        state;
  logic          armed;
  logic [PW-1:0] presc;
  logic [11:0]   count;
  logic [11:0]   count_dec;
  logic [1:0]    hp;
  logic          req;
  logic          clr;
  logic          ledr_q;
  logic [2:0]    key_s1;
  logic [2:0]    key_s2;
  logic [2:0]    key_prev;
  logic [2:0]    key_edge;
  logic          tick;
  logic          unused_keys;

  assign unused_keys = ^KEY[6:3];
  assign key_edge    = key_s2 & ~key_prev;
  assign tick        = (presc == PRESC_MAX);

  always_comb begin
    count_dec = count;
    if (count[3:0] != 4'd0) begin
      count_dec[3:0] = count[3:0] - 4'd1;
    end else begin
      count_dec[3:0] = 4'd9;
      if (count[7:4] != 4'd0) begin
        count_dec[7:4] = count[7:4] - 4'd1;
      end else begin
        count_dec[7:4]  = 4'd9;
        count_dec[11:8] = count[11:8] - 4'd1;
      end
    end
  end

`ifdef TIME_BONUS_EN
  localparam logic [3:0] BONUS_ONES = 4'(BONUS_SEC % 10);
  localparam logic [3:0] BONUS_TENS = 4'(BONUS_SEC / 10);

  logic [4:0]  sum0, sum1, sum2;
  logic        c0, c1, c2;
  logic [11:0] count_bonus;

  // Digit-serial BCD add; a carry out of the hundreds digit saturates at 999.
  always_comb begin
    sum0 = {1'b0, count[3:0]} + {1'b0, BONUS_ONES};
    c0   = (sum0 > 5'd9);
    if (c0) sum0 = sum0 - 5'd10;
    sum1 = {1'b0, count[7:4]} + {1'b0, BONUS_TENS} + {4'd0, c0};
    c1   = (sum1 > 5'd9);
    if (c1) sum1 = sum1 - 5'd10;
    sum2 = {1'b0, count[11:8]} + {4'd0, c1};
    c2   = (sum2 > 5'd9);
    count_bonus = c2 ? 12'h999 : {sum2[3:0], sum1[3:0], sum0[3:0]};
  end
`else
  localparam int unused_bonus = BONUS_SEC;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      presc    <= '0;
      count    <= TL_BCD;
      hp       <= HP_RST;
      req      <= 1'b0;
      clr      <= 1'b0;
      ledr_q   <= 1'b0;
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
    end else begin
      key_s1   <= KEY[2:0];
      key_s2   <= key_s1;
      key_prev <= key_s2;
      req      <= 1'b0;
      clr      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_edge[0]) state <= S_READY;
        end
        S_READY: begin
          if (key_edge[1]) begin
            state <= S_INPUT;
            count <= TL_BCD;
            presc <= '0;
            clr   <= 1'b1;
          end
        end
        S_INPUT: begin
          // Expiry beats a simultaneous submit.
          if (count == 12'h000) begin
            state <= S_OVER;
          end else begin
            if (tick) begin
              presc <= '0;
              count <= count_dec;
            end else begin
              presc <= presc + 1'b1;
            end
            if (key_edge[2]) begin
              state <= S_JUDGE;
              armed <= 1'b0;
              req   <= 1'b1;
            end
          end
        end
        S_JUDGE: begin
          // The entry cycle may still carry the previous result, so skip it.
          if (!armed) begin
            armed <= 1'b1;
          end else if (WRONG || JUDG == 2'b11) begin
            if (hp <= 2'd1) begin
              hp    <= 2'd0;
              state <= S_OVER;
            end else begin
              hp    <= hp - 2'd1;
              state <= S_INPUT;
              clr   <= 1'b1;
            end
          end else if (JUDG == 2'b01) begin
            state <= S_INPUT;
            clr   <= 1'b1;
`ifdef TIME_BONUS_EN
            count <= count_bonus;
`endif
          end else if (JUDG == 2'b10) begin
            state  <= S_CLEAR;
            ledr_q <= 1'b1;
          end
        end
        S_CLEAR, S_OVER: begin
          if (key_edge[0]) begin
            state  <= S_IDLE;
            hp     <= HP_RST;
            count  <= TL_BCD;
            presc  <= '0;
            ledr_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign MODE       = state;
  assign JUDGE_REQ  = req;
  assign INPUT_CLR  = clr;
  assign HP_OUT     = hp;
  assign COUNT1_OUT = count[3:0];
  assign COUNT2_OUT = count[7:4];
  assign COUNT3_OUT = count[11:8];
  assign LEDR       = ledr_q;

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Directed bench for factor_game_ctrl (TICK_DIV=4, TIME_LIMIT=3, HP_INIT=3).
// With TIME_BONUS_EN defined, a second instance (TIME_LIMIT=997) exercises the timer bonus.
module tb_factor_game_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] KEY;
  logic [1:0] JUDG;
  logic       WRONG;
  logic [2:0] MODE;
  logic       JUDGE_REQ;
  logic       INPUT_CLR;
  logic [1:0] HP_OUT;
  logic [3:0] COUNT1_OUT, COUNT2_OUT, COUNT3_OUT;
  logic       LEDR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  factor_game_ctrl #(.TICK_DIV(4), .TIME_LIMIT(3), .HP_INIT(3), .BONUS_SEC(5)) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .JUDG(JUDG), .WRONG(WRONG),
    .MODE(MODE), .JUDGE_REQ(JUDGE_REQ), .INPUT_CLR(INPUT_CLR), .HP_OUT(HP_OUT),
    .COUNT1_OUT(COUNT1_OUT), .COUNT2_OUT(COUNT2_OUT), .COUNT3_OUT(COUNT3_OUT), .LEDR(LEDR)
  );

`ifdef TIME_BONUS_EN
  logic [2:0] b_mode;
  logic       b_req, b_clr, b_ledr;
  logic [1:0] b_hp;
  logic [3:0] b_c1, b_c2, b_c3;

  factor_game_ctrl #(.TICK_DIV(4), .TIME_LIMIT(997), .HP_INIT(3), .BONUS_SEC(5)) u_bonus (
    .CLK(CLK), .RST(RST), .KEY(KEY), .JUDG(JUDG), .WRONG(WRONG),
    .MODE(b_mode), .JUDGE_REQ(b_req), .INPUT_CLR(b_clr), .HP_OUT(b_hp),
    .COUNT1_OUT(b_c1), .COUNT2_OUT(b_c2), .COUNT3_OUT(b_c3), .LEDR(b_ledr)
  );
`endif

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // One-cycle key pulse; returns on the negedge after the edge where MODE reacts.
  task automatic key_pulse(input int idx);
    KEY[idx] = 1'b1;
    tick();
    KEY[idx] = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [11:0] cnt();
    return {COUNT3_OUT, COUNT2_OUT, COUNT1_OUT};
  endfunction

  initial begin
    RST = 1'b1; KEY = '0; JUDG = 2'b00; WRONG = 1'b0;
    tick(); tick();
    check("rst_mode", 12'(MODE), 12'd0);
    check("rst_hp", 12'(HP_OUT), 12'd3);
    check("rst_count", cnt(), 12'h003);
    check("rst_pulses", {10'd0, JUDGE_REQ, INPUT_CLR}, 12'd0);
    check("rst_ledr", 12'(LEDR), 12'd0);
    RST = 1'b0;
    tick();

    key_pulse(1);
    key_pulse(2);
    check("idle_ignores_keys", 12'(MODE), 12'd0);

    // Start flow with held key levels
    KEY = 7'b0000001;
    tick(); tick();
    check("start_latency", 12'(MODE), 12'd0);
    tick();
    check("mode_ready", 12'(MODE), 12'd1);
    KEY = 7'b0000011;
    tick(); tick(); tick();
    check("mode_input", 12'(MODE), 12'd2);
    check("clr_on_entry", 12'(INPUT_CLR), 12'd1);
    check("count_loaded", cnt(), 12'h003);
    tick();
    check("clr_one_cycle", 12'(INPUT_CLR), 12'd0);

    // Timeout
    tick(); tick();
    check("to_hold3", cnt(), 12'h003);
    tick();
    check("to_2", cnt(), 12'h002);
    repeat (4) tick();
    check("to_1", cnt(), 12'h001);
    repeat (4) tick();
    check("to_0", cnt(), 12'h000);
    check("to_still_input", 12'(MODE), 12'd2);
    tick();
    check("to_over", 12'(MODE), 12'd5);
    check("to_ledr", 12'(LEDR), 12'd0);
    KEY = '0;
    tick(); tick();
    key_pulse(0);
    check("over_to_idle", 12'(MODE), 12'd0);
    check("over_reload", cnt(), 12'h003);

    // Wrong answers
    key_pulse(0);
    key_pulse(1);
    check("wr_input", 12'(MODE), 12'd2);
    for (int i = 0; i < 3; i++) begin
      key_pulse(2);
      check("wr_judge", 12'(MODE), 12'd3);
      check("wr_req", 12'(JUDGE_REQ), 12'd1);
      JUDG = 2'b11;
      tick();
      check("wr_req_once", 12'(JUDGE_REQ), 12'd0);
      tick();
      JUDG = 2'b00;
      if (i < 2) begin
        check("wr_back_input", 12'(MODE), 12'd2);
        check("wr_hp", 12'(HP_OUT), 12'(2 - i));
        check("wr_clr", 12'(INPUT_CLR), 12'd1);
      end else begin
        check("wr_over", 12'(MODE), 12'd5);
        check("wr_hp0", 12'(HP_OUT), 12'd0);
      end
    end
    tick();
    check("wr_hp_held", 12'(HP_OUT), 12'd0);
    key_pulse(0);
    check("wr_idle", 12'(MODE), 12'd0);
    check("wr_hp_reload", 12'(HP_OUT), 12'd3);

    // Clear flow
    key_pulse(0);
    key_pulse(1);
    key_pulse(2);
    check("cl_judge", 12'(MODE), 12'd3);
    JUDG = 2'b01;
    tick(); tick();
    JUDG = 2'b00;
    check("cl_correct_input", 12'(MODE), 12'd2);
    check("cl_correct_clr", 12'(INPUT_CLR), 12'd1);
    check("cl_count_same", cnt(), 12'h003);
    key_pulse(2);
    JUDG = 2'b10;
    tick(); tick();
    check("cl_clear", 12'(MODE), 12'd4);
    check("cl_ledr", 12'(LEDR), 12'd1);
    check("cl_count_held", cnt(), 12'h002);
    tick(); tick();
    check("cl_still_clear", 12'(MODE), 12'd4);
    JUDG = 2'b00;
    key_pulse(0);
    check("cl_idle", 12'(MODE), 12'd0);
    check("cl_hp", 12'(HP_OUT), 12'd3);
    check("cl_count", cnt(), 12'h003);
    check("cl_ledr_off", 12'(LEDR), 12'd0);

    // Stale result ignored, WRONG beats JUDG
    key_pulse(0);
    key_pulse(1);
    key_pulse(2);
    JUDG = 2'b01;
    tick();
    check("stale_ignored", 12'(MODE), 12'd3);
    WRONG = 1'b1; JUDG = 2'b10;
    tick();
    WRONG = 1'b0; JUDG = 2'b00;
    check("prio_mode", 12'(MODE), 12'd2);
    check("prio_hp", 12'(HP_OUT), 12'd2);

    // Async reset in JUDGE
    key_pulse(2);
    check("ar_judge", 12'(MODE), 12'd3);
    #2 RST = 1'b1;
    #1;
    check("ar_mode", 12'(MODE), 12'd0);
    check("ar_hp", 12'(HP_OUT), 12'd3);
    check("ar_req", 12'(JUDGE_REQ), 12'd0);
    tick();
    RST = 1'b0;
    tick();

`ifdef TIME_BONUS_EN
    begin
      int n;
      key_pulse(0);
      key_pulse(1);
      check("b_load", {b_c3, b_c2, b_c1}, 12'h997);
      key_pulse(2);
      tick();
      JUDG = 2'b01;
      tick();
      JUDG = 2'b00;
      check("b_mode", 12'(b_mode), 12'd2);
      check("b_saturate", {b_c3, b_c2, b_c1}, 12'h999);
      n = 0;
      while ({b_c3, b_c2, b_c1} != 12'h058 && n < 5000) begin
        tick();
        n++;
      end
      check("b_wait_058", 12'(n < 5000), 12'd1);
      key_pulse(2);
      check("b_frozen", {b_c3, b_c2, b_c1}, 12'h058);
      tick();
      JUDG = 2'b01;
      tick();
      JUDG = 2'b00;
      check("b_add", {b_c3, b_c2, b_c1}, 12'h063);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
